// File: rtl/serial_src_pkg.sv
// Shared types and constants for the serial bit source feeding the 100/001 detector.
package serial_src_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry holding register: written on a transfer, drained on a shift-register reload.
module word_hold_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data,
   output logic             full
);

   // NOTE: the data word is reset too, so a reset never leaves stale payload visible downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data <= '0;
         full <= 1'b0;
      end else if (wr_en) begin
         data <= wr_data;
         full <= 1'b1;
      end else if (rd_en) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per clock on out,
// one-word hold for gapless streaming, underrun flag and saturating counter.
module serial_bit_source
   import serial_src_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             underrun_clr,
   output logic             out,
   output logic             out_valid,
   output logic             frame_start,
   output logic             underrun,
   output logic [CNT_W-1:0] underrun_cnt
);

   localparam int             BCW      = $clog2(WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [BCW-1:0]   bit_cnt;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             xfer;
   logic             last;
   logic             load;
   logic [WIDTH-1:0] load_word;

   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   assign s_ready = ~hold_full;
   assign xfer    = s_valid & s_ready;
   assign last    = (state == SHIFT) && (bit_cnt == LAST_BIT);

   // A held word always beats the bypass path; in IDLE the hold is empty so s_data is chosen.
   always_comb begin
      load_word = hold_full ? hold_data : s_data;
      load      = ((state == IDLE) && xfer) || (last && (hold_full || xfer));
   end

   word_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (xfer && (state == SHIFT) && !last),
      .wr_data (s_data),
      .rd_en   (last && hold_full),
      .data    (hold_data),
      .full    (hold_full)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sr          <= '0;
         bit_cnt     <= '0;
         out         <= IDLE_BIT;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         if (load) begin
            state       <= SHIFT;
            sr          <= load_word;
            bit_cnt     <= '0;
            out         <= head(load_word);
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
         end else if (state == SHIFT && !last) begin
            sr      <= advance(sr);
            bit_cnt <= bit_cnt + 1'b1;
            out     <= head(advance(sr));
         end else if (last) begin
            state     <= IDLE;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            underrun  <= 1'b1;
         end
      end
   end

   // Counts the visible underrun pulse; a coincident clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underrun_cnt <= '0;
      end else if (underrun_clr) begin
         underrun_cnt <= '0;
      end else if (underrun) begin
         underrun_cnt <= sat_inc(underrun_cnt);
      end
   end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: MSB-first instance and an LSB-first / idle-high instance.
module tb_serial_bit_source;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       underrun_clr = 1'b0;
   logic       s_ready, out, out_valid, frame_start, underrun;
   logic [7:0] underrun_cnt;

   logic [7:0] b_s_data = '0;
   logic       b_s_valid = 1'b0;
   logic       b_s_ready, b_out, b_out_valid, b_frame_start, b_underrun;
   logic [7:0] b_underrun_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .underrun_clr (underrun_clr),
      .out          (out),
      .out_valid    (out_valid),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
      .clk          (clk),
      .reset        (reset),
      .s_data       (b_s_data),
      .s_valid      (b_s_valid),
      .s_ready      (b_s_ready),
      .underrun_clr (1'b0),
      .out          (b_out),
      .out_valid    (b_out_valid),
      .frame_start  (b_frame_start),
      .underrun     (b_underrun),
      .underrun_cnt (b_underrun_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sends one word to an idle DUT and waits (bounded) for its underrun pulse.
   task automatic send_iso(input logic [7:0] d);
      int c;
      s_data  = d;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      c = 0;
      while (!underrun && c < 20) begin
         tick();
         c++;
      end
      check("iso_underrun_seen", underrun, 1);
   endtask

   initial begin
      logic [7:0]  w;
      logic [15:0] w16;

      repeat (2) tick();
      reset = 1'b0;

      // Reset mid-word with a word also held
      s_data  = 8'hFF;
      s_valid = 1'b1;
      tick();
      s_data = 8'h0F;
      tick();
      s_valid = 1'b0;
      tick();
      check("pre_reset_ready", s_ready, 0);
      check("pre_reset_valid", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_valid", out_valid, 0);
      check("async_reset_ready", s_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) tick();
      check("idle_out", out, 0);
      check("idle_valid", out_valid, 0);
      check("idle_ready", s_ready, 1);
      check("idle_cnt", underrun_cnt, 0);
      check("idle_underrun", underrun, 0);
      check("lsb_idle_out", b_out, 1);

      // Single word 0x90, MSB first
      w       = 8'h90;
      s_data  = w;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("single_out", out, w[7-k]);
         check("single_valid", out_valid, 1);
         check("single_fs", frame_start, (k == 0));
         check("single_ur", underrun, 0);
         tick();
      end
      check("single_ur_pulse", underrun, 1);
      check("single_valid_fall", out_valid, 0);
      check("single_idle_out", out, 0);
      tick();
      check("single_ur_once", underrun, 0);
      check("single_cnt", underrun_cnt, 1);

      // Back-to-back through the hold register
      w16     = 16'hA53C;
      s_data  = 8'hA5;
      s_valid = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         check("b2b_out", out, w16[15-k]);
         check("b2b_valid", out_valid, 1);
         check("b2b_fs", frame_start, (k == 0 || k == 8));
         check("b2b_ur", underrun, 0);
         check("b2b_ready", s_ready, !(k >= 1 && k <= 7));
         if (k == 0) s_data = 8'h3C;
         if (k == 1) s_valid = 1'b0;
         tick();
      end
      check("b2b_ur_pulse", underrun, 1);
      tick();
      check("b2b_cnt", underrun_cnt, 2);

      // Bypass on the last bit
      w16     = 16'h0180;
      s_data  = 8'h01;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check("byp_out", out, w16[15-k]);
         check("byp_valid", out_valid, 1);
         check("byp_fs", frame_start, (k == 0 || k == 8));
         if (k == 7) begin
            s_data  = 8'h80;
            s_valid = 1'b1;
         end
         if (k == 8) s_valid = 1'b0;
         tick();
      end
      check("byp_ur_pulse", underrun, 1);
      tick();
      check("byp_cnt", underrun_cnt, 3);

      // LSB first with idle-high
      w         = 8'h06;
      b_s_data  = w;
      b_s_valid = 1'b1;
      tick();
      b_s_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("lsb_out", b_out, w[k]);
         check("lsb_fs", b_frame_start, (k == 0));
         check("lsb_valid", b_out_valid, 1);
         tick();
      end
      check("lsb_idle_after", b_out, 1);
      check("lsb_ur_pulse", b_underrun, 1);

      // Saturation and clear-wins
      for (int i = 0; i < 100; i++) begin
         send_iso(8'(i));
         tick();
      end
      check("cnt_103", underrun_cnt, 103);
      for (int i = 0; i < 200; i++) begin
         send_iso(8'(i + 7));
         tick();
      end
      check("cnt_saturated", underrun_cnt, 255);
      send_iso(8'h55);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("clr_wins_cnt", underrun_cnt, 0);
      check("clr_wins_ur", underrun, 0);
      send_iso(8'hAA);
      tick();
      check("cnt_after_clr", underrun_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
